mips_debug_sequencer: RTL and testbench

//  Parametrised debug controller driving the MIPS core's debug interface (mdb_ena, inm_du_areg/inm_duc1,
//  inm_du_amem/inm_duc2) from a command stream: free-run, N-cycle step, register-file dump, data-memory dump.

---
 rtl/mips_debug_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mips_debug_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_sequencer.sv
// Debug sequencer for the MIPS core: free-run, N-cycle step, register and data-memory dumps.
// Optional breakpoint support is compiled in with DBG_BREAKPOINT_EN.
module mips_debug_sequencer #(
    parameter int unsigned MSB       = 31,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [MSB:0]   cmd_arg,
    input  logic           PC_endM,
    input  logic [MSB:0]   w_rd_data1,
    input  logic [MSB:0]   out_MEM_rdd,
    output logic           mdb_ena,
    output logic [4:0]     inm_du_areg,
    output logic           inm_duc1,
    output logic [MSB:0]   inm_du_amem,
    output logic           inm_duc2,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [MSB:0]   dout_data,
    output logic           dout_last,
    output logic           busy,
    output logic           halted_end
`ifdef DBG_BREAKPOINT_EN
    ,
    input  logic [MSB:0]   m_PC,
    output logic           bp_hit
`endif
);

    localparam int unsigned W         = MSB + 1;
    localparam int unsigned MAX_WORDS = (NREGS > MEM_WORDS) ? NREGS : MEM_WORDS;
    localparam int unsigned IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_STEP      = 3'd2;
    localparam logic [2:0] S_SCAN_ADDR = 3'd3;
    localparam logic [2:0] S_SCAN_WAIT = 3'd4;
    localparam logic [2:0] S_SCAN_OUT  = 3'd5;

    localparam logic [1:0] OP_RUN       = 2'b00;
    localparam logic [1:0] OP_STEP      = 2'b01;
    localparam logic [1:0] OP_DUMP_REGS = 2'b10;
    localparam logic [1:0] OP_DUMP_MEM  = 2'b11;

    logic [2:0]        r_state,      w_state_nxt;
    logic [W-1:0]      r_count,      w_count_nxt;
    logic [IDX_W-1:0]  r_idx,        w_idx_nxt;
    logic              r_is_mem,     w_is_mem_nxt;
    logic [WAIT_W-1:0] r_wait,       w_wait_nxt;
    logic              r_duc1,       w_duc1_nxt;
    logic              r_duc2,       w_duc2_nxt;
    logic [4:0]        r_areg,       w_areg_nxt;
    logic [W-1:0]      r_amem,       w_amem_nxt;
    logic              r_dout_valid, w_dout_valid_nxt;
    logic [W-1:0]      r_dout_data,  w_dout_data_nxt;
    logic              r_dout_last,  w_dout_last_nxt;
    logic              r_halted,     w_halted_nxt;
    logic              w_mdb_ena;
    logic              w_bp_match;
    logic              w_stop;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx_inc;

`ifdef DBG_BREAKPOINT_EN
    logic [W-1:0]      r_bp,         w_bp_nxt;
    logic              r_bp_armed,   w_bp_armed_nxt;
    logic              r_bp_hit,     w_bp_hit_nxt;

    assign w_bp_match = r_bp_armed && (m_PC == r_bp);
`else
    assign w_bp_match = 1'b0;
`endif

    assign w_stop    = PC_endM | w_bp_match;
    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_last    = r_is_mem ? (r_idx == IDX_W'(MEM_WORDS - 1))
                                : (r_idx == IDX_W'(NREGS - 1));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_idx_nxt        = r_idx;
        w_is_mem_nxt     = r_is_mem;
        w_wait_nxt       = r_wait;
        w_duc1_nxt       = r_duc1;
        w_duc2_nxt       = r_duc2;
        w_areg_nxt       = r_areg;
        w_amem_nxt       = r_amem;
        w_dout_valid_nxt = r_dout_valid;
        w_dout_data_nxt  = r_dout_data;
        w_dout_last_nxt  = r_dout_last;
        w_halted_nxt     = r_halted;
        w_mdb_ena        = 1'b0;
`ifdef DBG_BREAKPOINT_EN
        w_bp_nxt         = r_bp;
        w_bp_armed_nxt   = r_bp_armed;
        w_bp_hit_nxt     = r_bp_hit;
`endif

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN, OP_STEP: begin
                            w_halted_nxt = 1'b0;
`ifdef DBG_BREAKPOINT_EN
                            w_bp_hit_nxt = 1'b0;
`endif
                            w_count_nxt  = (cmd_op == OP_STEP) ? cmd_arg : '0;
                            // Core already at end of program: accept but never enable
                            if (PC_endM) begin
                                w_halted_nxt = 1'b1;
                            end else begin
                                w_state_nxt = (cmd_op == OP_RUN) ? S_RUN : S_STEP;
                            end
                        end
                        OP_DUMP_REGS: begin
                            w_idx_nxt    = '0;
                            w_is_mem_nxt = 1'b0;
                            w_duc1_nxt   = 1'b1;
                            w_duc2_nxt   = 1'b0;
                            w_areg_nxt   = '0;
                            w_state_nxt  = S_SCAN_ADDR;
                        end
                        default: begin
`ifdef DBG_BREAKPOINT_EN
                            if (cmd_arg[MSB]) begin
                                w_bp_nxt       = {1'b0, cmd_arg[MSB-1:0]};
                                w_bp_armed_nxt = 1'b1;
                            end else begin
                                w_idx_nxt    = '0;
                                w_is_mem_nxt = 1'b1;
                                w_duc1_nxt   = 1'b0;
                                w_duc2_nxt   = 1'b1;
                                w_amem_nxt   = '0;
                                w_state_nxt  = S_SCAN_ADDR;
                            end
`else
                            w_idx_nxt    = '0;
                            w_is_mem_nxt = 1'b1;
                            w_duc1_nxt   = 1'b0;
                            w_duc2_nxt   = 1'b1;
                            w_amem_nxt   = '0;
                            w_state_nxt  = S_SCAN_ADDR;
`endif
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_halted_nxt = r_halted | PC_endM;
`ifdef DBG_BREAKPOINT_EN
                    w_bp_hit_nxt = r_bp_hit | w_bp_match;
`endif
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_mdb_ena = 1'b1;
                end
            end
            S_STEP: begin
                if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (w_stop) begin
                    w_halted_nxt = r_halted | PC_endM;
`ifdef DBG_BREAKPOINT_EN
                    w_bp_hit_nxt = r_bp_hit | w_bp_match;
`endif
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_mdb_ena   = 1'b1;
                    w_count_nxt = r_count - W'(1);
                    if (r_count == W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_SCAN_ADDR: begin
                w_wait_nxt  = WAIT_W'(RD_LAT - 1);
                w_state_nxt = S_SCAN_WAIT;
            end
            S_SCAN_WAIT: begin
                // Read data is valid in the last wait cycle; capture it on the way out
                if (r_wait == '0) begin
                    w_dout_data_nxt  = r_is_mem ? out_MEM_rdd : w_rd_data1;
                    w_dout_valid_nxt = 1'b1;
                    w_dout_last_nxt  = w_last;
                    w_state_nxt      = S_SCAN_OUT;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                end
            end
            S_SCAN_OUT: begin
                if (dout_ready) begin
                    w_dout_valid_nxt = 1'b0;
                    w_dout_last_nxt  = 1'b0;
                    if (w_last) begin
                        w_duc1_nxt  = 1'b0;
                        w_duc2_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_areg_nxt  = r_is_mem ? r_areg : 5'(w_idx_inc);
                        w_amem_nxt  = r_is_mem ? W'({w_idx_inc, 2'b00}) : r_amem;
                        w_state_nxt = S_SCAN_ADDR;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_is_mem     <= 1'b0;
            r_wait       <= '0;
            r_duc1       <= 1'b0;
            r_duc2       <= 1'b0;
            r_areg       <= '0;
            r_amem       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_dout_last  <= 1'b0;
            r_halted     <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
            r_bp         <= '0;
            r_bp_armed   <= 1'b0;
            r_bp_hit     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_idx        <= w_idx_nxt;
            r_is_mem     <= w_is_mem_nxt;
            r_wait       <= w_wait_nxt;
            r_duc1       <= w_duc1_nxt;
            r_duc2       <= w_duc2_nxt;
            r_areg       <= w_areg_nxt;
            r_amem       <= w_amem_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_dout_data  <= w_dout_data_nxt;
            r_dout_last  <= w_dout_last_nxt;
            r_halted     <= w_halted_nxt;
`ifdef DBG_BREAKPOINT_EN
            r_bp         <= w_bp_nxt;
            r_bp_armed   <= w_bp_armed_nxt;
            r_bp_hit     <= w_bp_hit_nxt;
`endif
        end
    end

    // mdb_ena is gated combinationally so the core stops in the cycle the stop condition appears
    assign mdb_ena     = w_mdb_ena;
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign inm_duc1    = r_duc1;
    assign inm_duc2    = r_duc2;
    assign inm_du_areg = r_areg;
    assign inm_du_amem = r_amem;
    assign dout_valid  = r_dout_valid;
    assign dout_data   = r_dout_data;
    assign dout_last   = r_dout_last;
    assign halted_end  = r_halted;
`ifdef DBG_BREAKPOINT_EN
    assign bp_hit      = r_bp_hit;
`endif

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Bench for mips_debug_sequencer: run/step vector table, scoreboarded dumps, reset abort, optional breakpoint.
module tb_mips_debug_sequencer;

    localparam int unsigned MSB       = 31;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned MEM_WORDS = 64;
    localparam int unsigned RD_LAT    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        PC_endM;
    logic [31:0] w_rd_data1;
    logic [31:0] out_MEM_rdd;
    logic        mdb_ena;
    logic [4:0]  inm_du_areg;
    logic        inm_duc1;
    logic [31:0] inm_du_amem;
    logic        inm_duc2;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        busy;
    logic        halted_end;
`ifdef DBG_BREAKPOINT_EN
    logic [31:0] m_PC;
    logic        bp_hit;
`endif

    always #5 clk = ~clk;

    mips_debug_sequencer #(
        .MSB(MSB), .NREGS(NREGS), .MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .PC_endM(PC_endM), .w_rd_data1(w_rd_data1), .out_MEM_rdd(out_MEM_rdd),
        .mdb_ena(mdb_ena), .inm_du_areg(inm_du_areg), .inm_duc1(inm_duc1),
        .inm_du_amem(inm_du_amem), .inm_duc2(inm_duc2),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .busy(busy), .halted_end(halted_end)
`ifdef DBG_BREAKPOINT_EN
        , .m_PC(m_PC), .bp_hit(bp_hit)
`endif
    );

    function automatic logic [31:0] mem_word(input int j);
        return 32'h1000_0000 + 32'(j) * 32'h0001_0011;
    endfunction

    // Register file and data memory with RD_LAT=2 pipelines; unselected ports return junk
    logic [31:0] reg_p1, reg_p2, mem_p1, mem_p2;
    always @(posedge clk) begin
        reg_p1 <= inm_duc1 ? 32'(inm_du_areg) * 32'd3 : 32'hDEAD_BEEF;
        reg_p2 <= reg_p1;
        mem_p1 <= inm_duc2 ? mem_word(int'(inm_du_amem[31:2])) : 32'hBAD0_BAD0;
        mem_p2 <= mem_p1;
    end
    assign w_rd_data1  = reg_p2;
    assign out_MEM_rdd = mem_p2;

`ifdef DBG_BREAKPOINT_EN
    always @(posedge clk) begin
        if (reset)        m_PC <= 32'h0;
        else if (mdb_ena) m_PC <= m_PC + 32'd4;
    end
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [31:0] arg);
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready before issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
        int          end_at;   // cycle after acceptance on which PC_endM is raised (0 = never)
        int          exp_en;
        logic        exp_halt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        last;
    } dump_exp_t;

    dump_exp_t sb_q[$];

    // Step/run vector: counts enabled cycles until busy drops
    task automatic run_vec(input vec_t v, input int idx);
        int  en = 0;
        bit  done = 0;
        string nm;
        issue_cmd(v.op, v.arg);
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            PC_endM = (c == v.end_at);
            #1;
            if (!busy) done = 1;
            else if (mdb_ena) en++;
        end
        PC_endM = 1'b0;
        nm = $sformatf("vec%0d", idx);
        chk({nm, " completes"}, 32'(done), 32'd1);
        chk({nm, " enabled cycles"}, 32'(en), 32'(v.exp_en));
        chk({nm, " halted_end"}, 32'(halted_end), 32'(v.exp_halt));
        chk({nm, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_dump(input bit is_mem, input bit toggle, input int abort_at);
        int          n = is_mem ? int'(MEM_WORDS) : int'(NREGS);
        int          taken = 0, cyc = 0, last_hs = 0, gap = -1, mdb_seen = 0, both = 0;
        bit          prev_hold = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        dump_exp_t   e;
        bit          aborted = 0;
        string       nm = is_mem ? "mem" : "regs";
        for (int i = 0; i < n; i++) begin
            e.data = is_mem ? mem_word(i) : 32'(i) * 32'd3;
            e.addr = is_mem ? 32'(i) * 32'd4 : 32'(i);
            e.last = (i == n - 1);
            sb_q.push_back(e);
        end
        dout_ready = 1'b1;
        issue_cmd(is_mem ? 2'b11 : 2'b10, 32'h0);
        while (sb_q.size() > 0 && cyc < 3000 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (mdb_ena) mdb_seen++;
            if (inm_duc1 && inm_duc2) both++;
            if (prev_hold) begin
                chk({nm, " hold valid"}, 32'(dout_valid), 32'd1);
                chk({nm, " hold data"}, dout_data, prev_data);
                chk({nm, " hold last"}, 32'(dout_last), 32'(prev_last));
            end
            if (toggle) dout_ready = ~dout_ready;
            if (dout_valid && taken == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk({nm, " abort busy"}, 32'(busy), 32'd0);
                chk({nm, " abort dout_valid"}, 32'(dout_valid), 32'd0);
                chk({nm, " abort duc2"}, 32'(inm_duc2), 32'd0);
                chk({nm, " abort cmd_ready"}, 32'(cmd_ready), 32'd1);
                reset = 1'b0;
                sb_q.delete();
                aborted = 1;
            end else if (dout_valid && dout_ready) begin
                e = sb_q.pop_front();
                chk($sformatf("%s word%0d data", nm, taken), dout_data, e.data);
                chk($sformatf("%s word%0d addr", nm, taken),
                    is_mem ? inm_du_amem : 32'(inm_du_areg), e.addr);
                chk($sformatf("%s word%0d last", nm, taken), 32'(dout_last), 32'(e.last));
                chk($sformatf("%s word%0d select", nm, taken),
                    {30'd0, inm_duc2, inm_duc1}, is_mem ? 32'd2 : 32'd1);
                if (taken == 1) gap = cyc - last_hs;
                last_hs   = cyc;
                taken++;
                prev_hold = 0;
            end else begin
                prev_hold = dout_valid;
                prev_data = dout_data;
                prev_last = dout_last;
            end
        end
        chk({nm, " scoreboard drained"}, 32'(sb_q.size()), 32'd0);
        if (abort_at >= 0) begin
            chk({nm, " words before abort"}, 32'(taken), 32'(abort_at));
        end else begin
            @(negedge clk);
            chk({nm, " selects low after"}, {30'd0, inm_duc2, inm_duc1}, 32'd0);
            chk({nm, " idle after"}, 32'(busy), 32'd0);
        end
        if (!toggle) chk({nm, " word spacing"}, 32'(gap), 32'(RD_LAT + 2));
        chk({nm, " core frozen"}, 32'(mdb_seen), 32'd0);
        chk({nm, " exclusive selects"}, 32'(both), 32'd0);
        dout_ready = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_arg    = 32'h0;
        PC_endM    = 1'b0;
        dout_ready = 1'b1;

        vecs[0] = '{op: 2'b01, arg: 32'd5,  end_at: 0,  exp_en: 5,  exp_halt: 1'b0};
        vecs[1] = '{op: 2'b01, arg: 32'd0,  end_at: 0,  exp_en: 0,  exp_halt: 1'b0};
        vecs[2] = '{op: 2'b00, arg: 32'd0,  end_at: 20, exp_en: 19, exp_halt: 1'b1};
        vecs[3] = '{op: 2'b01, arg: 32'd3,  end_at: 0,  exp_en: 3,  exp_halt: 1'b0};
        vecs[4] = '{op: 2'b01, arg: 32'd10, end_at: 4,  exp_en: 3,  exp_halt: 1'b1};
        vecs[5] = '{op: 2'b00, arg: 32'd0,  end_at: 1,  exp_en: 0,  exp_halt: 1'b1};
        vecs[6] = '{op: 2'b01, arg: 32'd1,  end_at: 0,  exp_en: 1,  exp_halt: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset mdb_ena", 32'(mdb_ena), 32'd0);
        chk("reset selects", {30'd0, inm_duc2, inm_duc1}, 32'd0);
        chk("reset areg", 32'(inm_du_areg), 32'd0);
        chk("reset amem", inm_du_amem, 32'd0);
        chk("reset dout", {29'd0, dout_valid, dout_last, busy}, 32'd0);
        chk("reset dout_data", dout_data, 32'd0);
        chk("reset halted_end", 32'(halted_end), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        run_dump(1'b0, 1'b1, -1);
        run_dump(1'b1, 1'b0, -1);
        run_dump(1'b1, 1'b0, 10);

`ifdef DBG_BREAKPOINT_EN
        begin
            int  en = 0;
            bit  done = 0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            issue_cmd(2'b11, 32'h8000_0040);
            @(negedge clk);
            chk("bp_set no dump", 32'(dout_valid), 32'd0);
            chk("bp_set idle", 32'(busy), 32'd0);
            issue_cmd(2'b00, 32'h0);
            for (int c = 1; c <= 300 && !done; c++) begin
                @(negedge clk);
                #1;
                if (!busy) done = 1;
                else if (mdb_ena) en++;
            end
            chk("bp run completes", 32'(done), 32'd1);
            chk("bp enabled cycles", 32'(en), 32'd16);
            chk("bp stop pc", m_PC, 32'h40);
            chk("bp_hit", 32'(bp_hit), 32'd1);
            chk("bp halted_end", 32'(halted_end), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
